// File: rtl/dcm_pkg.sv
// Shared types and helpers for the divider programming controller.
package dcm_pkg;

  localparam int unsigned PROG_W = 3;

  typedef logic [PROG_W-1:0] prog_t;

  localparam prog_t PROG_MAX = prog_t'(7);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StError
  } dcm_state_e;

  // One step up or down, clamped to the legal prog range.
  function automatic prog_t prog_step(input prog_t base, input logic up);
    if (up) begin
      return (base == PROG_MAX) ? base : base + prog_t'(1);
    end
    return (base == '0) ? base : base - prog_t'(1);
  endfunction

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// Request side and divider side of the prog controller, grouped as one bundle.
interface dcm_prog_ctrl_if import dcm_pkg::*; ();

  logic  inc_req;
  logic  dec_req;
  logic  set_req;
  prog_t set_val;
  prog_t dcm_prog_out;
  logic  dcm_update;
  prog_t dcm_prog_in;
  prog_t cur_prog;
  logic  busy;
  logic  error;

  // Controller view.
  modport slave (
    input  inc_req, dec_req, set_req, set_val, dcm_prog_out,
    output dcm_update, dcm_prog_in, cur_prog, busy, error
  );

  // User-interface / divider view.
  modport master (
    output inc_req, dec_req, set_req, set_val, dcm_prog_out,
    input  dcm_update, dcm_prog_in, cur_prog, busy, error
  );

endinterface

// File: rtl/dcm_ack_timer.sv
// Acknowledge timeout counter: cleared by clr_i, counts while en_i, and raises
// expired_o one cycle after the count has reached TIMEOUT_CYCLES-1. Sticky until clr_i.
module dcm_ack_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            expired_q;

  // Count up while enabled; hold at the last value once expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (en_i && !expired_q) begin
      if (cnt_q == CntLast) begin
        expired_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Sequences prog changes of the clock divider: decodes inc/dec/set requests,
// issues a one-cycle update, waits for prog_out to confirm, retries on
// timeout and flags an error once retries run out.
module dcm_prog_ctrl import dcm_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input logic            clk,
  input logic            rst,
  dcm_prog_ctrl_if.slave bus
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  dcm_state_e        state_q;
  prog_t             target_q;
  prog_t             pend_q;
  logic              pend_vld_q;
  logic [RetryW-1:0] retry_q;
  logic              upd_q;
  prog_t             prog_in_q;
  prog_t             cur_q;
  logic              busy_q;
  logic              err_q;

  prog_t base;
  prog_t req_val;
  prog_t launch_val;
  logic  req_vld;
  logic  req_act;
  logic  expired;

  dcm_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == StIssue),
    .en_i     (state_q == StWait),
    .expired_o(expired)
  );

  // Request decode: set wins, inc+dec together cancels; steps are relative
  // to the most recent intent (pending, then in-flight target, then confirmed).
  always_comb begin
    base    = pend_vld_q ? pend_q : (busy_q ? target_q : cur_q);
    req_vld = 1'b0;
    req_val = base;
    if (bus.set_req) begin
      req_vld = 1'b1;
      req_val = bus.set_val;
    end else if (bus.inc_req ^ bus.dec_req) begin
      req_vld = 1'b1;
      req_val = prog_step(base, bus.inc_req);
    end
    req_act    = req_vld && (req_val != base);
    launch_val = req_act ? req_val : pend_q;
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      target_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      retry_q    <= '0;
      upd_q      <= 1'b0;
      prog_in_q  <= '0;
      cur_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      // Requests outside IDLE are parked; the latest one overwrites.
      if (state_q != StIdle && req_act) begin
        pend_q     <= req_val;
        pend_vld_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (req_vld) begin
            err_q <= 1'b0;
          end
          pend_vld_q <= 1'b0;
          if ((req_act || pend_vld_q) && (launch_val != cur_q)) begin
            target_q  <= launch_val;
            prog_in_q <= launch_val;
            upd_q     <= 1'b1;
            busy_q    <= 1'b1;
            retry_q   <= '0;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          // A match in the expiry cycle still counts as success.
          if (bus.dcm_prog_out == target_q) begin
            cur_q   <= target_q;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (expired) begin
            if (retry_q < RetryMax) begin
              retry_q <= retry_q + RetryW'(1);
              upd_q   <= 1'b1;
              state_q <= StIssue;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StError;
            end
          end
        end
        StError: begin
          err_q      <= 1'b1;
          cur_q      <= bus.dcm_prog_out;
          pend_vld_q <= req_act;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.dcm_update  = upd_q;
  assign bus.dcm_prog_in = prog_in_q;
  assign bus.cur_prog    = cur_q;
  assign bus.busy        = busy_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Scoreboard bench for dcm_prog_ctrl: stimulus pushes expected update values
// and completion results; a monitor pops them as the DUT produces them.
module tb_dcm_prog_ctrl;
  import dcm_pkg::*;

  localparam int unsigned TO = 16;
  localparam int unsigned MR = 2;

  localparam int OpInc  = 0;
  localparam int OpDec  = 1;
  localparam int OpSet  = 2;
  localparam int OpBoth = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcm_prog_ctrl_if bus ();

  dcm_prog_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_n = 0;
  int err_n = 0;

  int exp_upd[$];
  int exp_cur[$];
  int exp_err[$];
  int upd_cyc[$];
  int upd_cnt  = 0;
  int fall_cyc = 0;
  int req_cyc  = 0;
  bit mon_en   = 1'b1;

  int   ref_cur   = 0;
  bit   echo_en   = 1'b1;
  int   echo_dly  = 3;
  int   echo_cnt  = -1;
  prog_t echo_val = '0;
  prog_t model_out = '0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vec_n++;
    if (act !== 32'(exp)) begin
      err_n++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Divider model: echoes prog_in to prog_out echo_dly cycles after update.
  initial begin
    bus.dcm_prog_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (echo_cnt > 0) begin
        echo_cnt--;
        if (echo_cnt == 0) begin
          model_out        = echo_val;
          bus.dcm_prog_out = model_out;
          echo_cnt         = -1;
        end
      end
      if (bus.dcm_update === 1'b1 && echo_en) begin
        echo_cnt = echo_dly;
        echo_val = bus.dcm_prog_in;
      end
    end
  end

  // Monitor: checks every update pulse and every completed transaction.
  initial begin
    logic busy_prev;
    bit   done_pend;
    int   e;
    busy_prev = 1'b0;
    done_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        done_pend = 1'b0;
      end else begin
        if (done_pend) begin
          done_pend = 1'b0;
          vec_n++;
          if (exp_cur.size() == 0) begin
            err_n++;
            $display("FAIL done_unexpected: got completion cur_prog=%0d, expected none",
                     bus.cur_prog);
          end else begin
            vec_n--;
            e = exp_cur.pop_front();
            chk("done_cur_prog", bus.cur_prog, e);
            e = exp_err.pop_front();
            chk("done_error", bus.error, e);
          end
        end
        if (bus.dcm_update === 1'b1) begin
          upd_cnt++;
          upd_cyc.push_back(cyc);
          vec_n++;
          if (exp_upd.size() == 0) begin
            err_n++;
            $display("FAIL upd_unexpected: got update prog_in=%0d, expected none",
                     bus.dcm_prog_in);
          end else begin
            vec_n--;
            e = exp_upd.pop_front();
            chk("upd_prog_in", bus.dcm_prog_in, e);
          end
        end
        if (busy_prev === 1'b1 && bus.busy === 1'b0) begin
          done_pend = 1'b1;
          fall_cyc  = cyc;
        end
      end
      busy_prev = bus.busy;
    end
  end

  task automatic req(input int op, input int val);
    @(posedge clk);
    #1;
    req_cyc     = cyc;
    bus.set_val = prog_t'(val);
    bus.inc_req = (op == OpInc) || (op == OpBoth);
    bus.dec_req = (op == OpDec) || (op == OpBoth);
    bus.set_req = (op == OpSet);
    @(posedge clk);
    #1;
    bus.inc_req = 1'b0;
    bus.dec_req = 1'b0;
    bus.set_req = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 3 && n < limit) begin
      @(negedge clk);
      n++;
      if (bus.busy !== 1'b0) quiet = 0;
      else quiet++;
    end
    vec_n++;
    if (quiet < 3) begin
      err_n++;
      $display("FAIL idle_timeout: busy still high after %0d cycles, expected idle", n);
    end
  endtask

  function automatic int ref_next(input int op, input int val, input int cur);
    case (op)
      OpInc:   return (cur < 7) ? cur + 1 : 7;
      OpDec:   return (cur > 0) ? cur - 1 : 0;
      OpSet:   return val;
      default: return cur;
    endcase
  endfunction

  // Idle-start transaction: predict pulses and outcome, then drive it.
  task automatic txn(input int op, input int val);
    int nv;
    nv = ref_next(op, val, ref_cur);
    if (nv != ref_cur) begin
      if ((echo_en && echo_dly <= int'(TO)) || int'(model_out) == nv) begin
        exp_upd.push_back(nv);
        exp_cur.push_back(nv);
        exp_err.push_back(0);
        ref_cur = nv;
      end else begin
        repeat (MR + 1) exp_upd.push_back(nv);
        exp_cur.push_back(int'(model_out));
        exp_err.push_back(1);
        ref_cur = int'(model_out);
      end
    end
    req(op, val);
    wait_idle(300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    int c0;
    bus.inc_req = 1'b0;
    bus.dec_req = 1'b0;
    bus.set_req = 1'b0;
    bus.set_val = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_update", bus.dcm_update, 0);
    chk("rst_prog_in", bus.dcm_prog_in, 0);
    chk("rst_cur_prog", bus.cur_prog, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_error", bus.error, 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // Basic step with echo delay 3.
    echo_dly = 3;
    u0 = upd_cnt;
    c0 = upd_cyc.size();
    txn(OpInc, 0);
    chk("basic_pulses", upd_cnt - u0, 1);
    chk("basic_upd_latency", upd_cyc[c0] - req_cyc, 1);
    chk("basic_done_latency", fall_cyc - req_cyc, 5);

    // Saturation at both ends.
    txn(OpSet, 7);
    u0 = upd_cnt;
    req(OpInc, 0);
    chk("sat_hi_busy", bus.busy, 0);
    wait_idle(50);
    chk("sat_hi_pulses", upd_cnt - u0, 0);
    txn(OpSet, 0);
    u0 = upd_cnt;
    req(OpDec, 0);
    chk("sat_lo_busy", bus.busy, 0);
    wait_idle(50);
    chk("sat_lo_pulses", upd_cnt - u0, 0);

    // Pending: set 2 then two incs while waiting -> 2 then 4.
    echo_dly = 6;
    u0 = upd_cnt;
    exp_upd.push_back(2);
    exp_cur.push_back(2);
    exp_err.push_back(0);
    exp_upd.push_back(4);
    exp_cur.push_back(4);
    exp_err.push_back(0);
    req(OpSet, 2);
    req(OpInc, 0);
    req(OpInc, 0);
    wait_idle(300);
    ref_cur = 4;
    chk("pend_pulses", upd_cnt - u0, 2);

    // Late match: echo lands when the timer reads TO-1.
    echo_dly = int'(TO);
    u0 = upd_cnt;
    c0 = upd_cyc.size();
    txn(OpSet, 6);
    chk("late_pulses", upd_cnt - u0, 1);
    chk("late_done_latency", fall_cyc - upd_cyc[c0], int'(TO) + 1);

    // Timeout with retries, then a new request clears the error.
    echo_en = 1'b0;
    u0 = upd_cnt;
    c0 = upd_cyc.size();
    txn(OpSet, 5);
    chk("to_pulses", upd_cnt - u0, MR + 1);
    chk("to_spacing1", upd_cyc[c0 + 1] - upd_cyc[c0], 18);
    chk("to_spacing2", upd_cyc[c0 + 2] - upd_cyc[c0 + 1], 18);
    chk("to_error", bus.error, 1);
    echo_en  = 1'b1;
    echo_dly = 2;
    txn(OpInc, 0);
    chk("to_error_cleared", bus.error, 0);

    // Async reset in WAIT.
    echo_en = 1'b0;
    exp_upd.push_back(5);
    req(OpSet, 5);
    repeat (4) @(posedge clk);
    mon_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_update", bus.dcm_update, 0);
    chk("arst_error", bus.error, 0);
    chk("arst_cur_prog", bus.cur_prog, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_upd.delete();
    exp_cur.delete();
    exp_err.delete();
    ref_cur = 0;
    echo_en = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    txn(OpInc, 0);
    chk("arst_after_cur", bus.cur_prog, 1);

    // Randomized idle-start transactions.
    for (int i = 0; i < 40; i++) begin
      echo_en  = ($urandom_range(0, 5) != 0);
      echo_dly = $urandom_range(1, TO);
      txn($urandom_range(0, 3), $urandom_range(0, 7));
    end

    repeat (4) @(negedge clk);
    chk("left_upd", exp_upd.size(), 0);
    chk("left_done", exp_cur.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
